// File: rtl/id_stage_pipe.sv
// Decode stage: register file, load-use and write-read hazard detection, and ID/EX pipeline register.
// Optional feature: define ID_STAGE_BYPASS_EN to forward same-cycle writeback data to the reads.
module id_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned CTRL_W    = 24,
    parameter int unsigned MEMRD_BIT = 0,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rs_in,
    input  logic [AW-1:0]     rt_in,
    input  logic [AW-1:0]     rd_in,
    input  logic [15:0]       imm16_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              wb_we,
    input  logic              wb_jal,
    input  logic              wb_ovf,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   busA,
    output logic [XLEN-1:0]   busB,
    output logic [XLEN-1:0]   pc_out,
    output logic [15:0]       imm16_out,
    output logic [AW-1:0]     rs_out,
    output logic [AW-1:0]     rt_out,
    output logic [AW-1:0]     rd_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              stall
);

    logic [XLEN-1:0] rf [NREG];
    logic [AW-1:0]   wr_tgt;
    logic            wr_live;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;
    logic            load_use;
    logic            advance;

    // Link writes always land in the last register; register 0 is never written.
    assign wr_tgt  = wb_jal ? AW'(NREG - 1) : wb_addr;
    assign wr_live = wb_we & ~wb_ovf & (wr_tgt != '0) & (32'(wr_tgt) < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
        end else if (wr_live) begin
            rf[wr_tgt] <= wb_data;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (32'(rs_in) < NREG) rd_a = rf[rs_in];
        if (32'(rt_in) < NREG) rd_b = rf[rt_in];
`ifdef ID_STAGE_BYPASS_EN
        if (wr_live && (wr_tgt == rs_in)) rd_a = wb_data;
        if (wr_live && (wr_tgt == rt_in)) rd_b = wb_data;
`endif
    end

    assign load_use = out_valid & ctrl_out[MEMRD_BIT] & (rt_out != '0) & in_valid
                    & ((rt_out == rs_in) | (rt_out == rt_in));

`ifdef ID_STAGE_BYPASS_EN
    assign stall = load_use;
`else
    // Without forwarding, a read racing a write waits one cycle for the stored value.
    assign stall = load_use | (wr_live & in_valid & ((wr_tgt == rs_in) | (wr_tgt == rt_in)));
`endif

    assign advance  = ~out_valid | out_ready;
    assign in_ready = flush | (advance & ~stall);

    // ID/EX register: flush beats stall, stall inserts a bubble, backpressure holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            busA      <= '0;
            busB      <= '0;
            pc_out    <= '0;
            imm16_out <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            ctrl_out  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_out  <= '0;
        end else if (advance) begin
            if (stall) begin
                out_valid <= 1'b0;
                ctrl_out  <= '0;
            end else begin
                out_valid <= in_valid;
                ctrl_out  <= in_valid ? ctrl_in : '0;
                busA      <= rd_a;
                busB      <= rd_b;
                pc_out    <= pc_in;
                imm16_out <= imm16_in;
                rs_out    <= rs_in;
                rt_out    <= rt_in;
                rd_out    <= rd_in;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed vector table, hand sequences, and random stimulus vs a reference model.
module tb_id_stage_pipe;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 24;
    localparam int unsigned AW   = 5;
`ifdef ID_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, wb_we, wb_jal, wb_ovf, flush, out_valid, out_ready, stall;
    logic [AW-1:0] rs_in, rt_in, rd_in, wb_addr, rs_out, rt_out, rd_out;
    logic [15:0] imm16_in, imm16_out;
    logic [XLEN-1:0] pc_in, wb_data, busA, busB, pc_out;
    logic [CW-1:0] ctrl_in, ctrl_out;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .imm16_in(imm16_in),
        .pc_in(pc_in), .ctrl_in(ctrl_in), .wb_we(wb_we), .wb_jal(wb_jal),
        .wb_ovf(wb_ovf), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .busA(busA), .busB(busB),
        .pc_out(pc_out), .imm16_out(imm16_out), .rs_out(rs_out), .rt_out(rt_out),
        .rd_out(rd_out), .ctrl_out(ctrl_out), .stall(stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; rs_in = '0; rt_in = '0; rd_in = '0; imm16_in = '0;
        pc_in = '0; ctrl_in = '0; wb_we = 1'b0; wb_jal = 1'b0; wb_ovf = 1'b0;
        wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic iv; logic [4:0] rs; logic [4:0] rt; logic [23:0] ctrl;
        logic ordy; logic fl; logic we; logic jal; logic ovf; logic [4:0] wa; logic [31:0] wd;
        logic st; logic rdy; logic ov; logic [23:0] ectrl;
        logic ca; logic [31:0] ea; logic cb; logic [31:0] eb;
    } vec_t;

    vec_t tbl [18];

    // Reference model state: architectural registers plus the ID/EX slot.
    logic [31:0] m_rf [NREG];
    logic m_v;
    logic [23:0] m_ctrl;
    logic [31:0] m_a, m_b, m_pc;
    logic [15:0] m_imm;
    logic [4:0] m_rs, m_rt, m_rd;

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic live, input logic [4:0] tgt);
        if (r == 5'd0) return 32'h0;
        if (BYP && live && tgt == r) return wb_data;
        return m_rf[r];
    endfunction

    initial begin
        logic live, e_st, e_rdy;
        logic [4:0] tgt;
        rst = 1'b1;
        idle();
        tbl[0]  = '{1'b0,5'd0,5'd0,24'h0,    1'b1,1'b0,1'b1,1'b0,1'b0,5'd5,32'h0000_1234, 1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[1]  = '{1'b1,5'd5,5'd0,24'h10,   1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h10,  1'b1,32'h1234,1'b1,32'h0};
        tbl[2]  = '{1'b0,5'd0,5'd0,24'h0,    1'b1,1'b0,1'b1,1'b1,1'b0,5'd2,32'h0040_0008, 1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[3]  = '{1'b0,5'd0,5'd0,24'h0,    1'b1,1'b0,1'b1,1'b0,1'b1,5'd9,32'hDEAD_BEEF, 1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[4]  = '{1'b0,5'd0,5'd0,24'h0,    1'b1,1'b0,1'b1,1'b0,1'b0,5'd0,32'hFFFF_FFFF, 1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[5]  = '{1'b1,5'd31,5'd9,24'h20,  1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h20,  1'b1,32'h0040_0008,1'b1,32'h0};
        tbl[6]  = '{1'b1,5'd0,5'd5,24'h40,   1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h40,  1'b1,32'h0,1'b1,32'h1234};
        tbl[7]  = '{1'b1,5'd0,5'd3,24'h1,    1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h1,   1'b1,32'h0,1'b1,32'h0};
        tbl[8]  = '{1'b1,5'd3,5'd5,24'h80,   1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b1,1'b0,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[9]  = '{1'b1,5'd3,5'd5,24'h80,   1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h80,  1'b1,32'h0,1'b1,32'h1234};
        tbl[10] = '{1'b1,5'd5,5'd31,24'h100, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b0,1'b1,24'h80,  1'b1,32'h0,1'b1,32'h1234};
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];
        tbl[13] = '{1'b1,5'd5,5'd31,24'h100, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[14] = '{1'b1,5'd0,5'd3,24'h1,    1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h1,   1'b1,32'h0,1'b1,32'h0};
        tbl[15] = '{1'b1,5'd3,5'd0,24'h200,  1'b1,1'b1,1'b1,1'b0,1'b0,5'd10,32'hAAAA_5555,1'b1,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[16] = '{1'b0,5'd0,5'd0,24'h0,    1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b0,24'h0,   1'b0,32'h0,1'b0,32'h0};
        tbl[17] = '{1'b1,5'd10,5'd9,24'h400, 1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0,         1'b0,1'b1,1'b1,24'h400, 1'b1,32'hAAAA_5555,1'b1,32'h0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_busA", busA, 32'h0);
        chk("rst_ctrl", {8'b0, ctrl_out}, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            in_valid = tbl[i].iv; rs_in = tbl[i].rs; rt_in = tbl[i].rt; rd_in = 5'(i);
            ctrl_in = tbl[i].ctrl; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            wb_we = tbl[i].we; wb_jal = tbl[i].jal; wb_ovf = tbl[i].ovf;
            wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
            pc_in = 32'h1000 + 32'(i * 4); imm16_in = 16'(i);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].st});
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk($sformatf("v%0d_ctrl", i), {8'b0, ctrl_out}, {8'b0, tbl[i].ectrl});
            if (tbl[i].ca) chk($sformatf("v%0d_busA", i), busA, tbl[i].ea);
            if (tbl[i].cb) chk($sformatf("v%0d_busB", i), busB, tbl[i].eb);
        end

        // Same-cycle write and read of r7
        idle();
        in_valid = 1'b1; rt_in = 5'd7; ctrl_in = 24'h800;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5;
        @(negedge clk);
        chk("wr_rd_stall", {31'b0, stall}, {31'b0, !BYP});
        @(posedge clk);
        #1;
`ifndef ID_STAGE_BYPASS_EN
        chk("wr_rd_bubble", {31'b0, out_valid}, 32'h0);
        wb_we = 1'b0;
        @(negedge clk);
        chk("wr_rd_stall2", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
`endif
        chk("wr_rd_valid", {31'b0, out_valid}, 32'h1);
        chk("wr_rd_busB", busB, 32'hA5A5);

        // Reset during backpressure discards held state
        idle();
        in_valid = 1'b1; rs_in = 5'd5; rt_in = 5'd7; ctrl_in = 24'h1000;
        @(posedge clk);
        #1;
        chk("pre_rst_busA", busA, 32'h1234);
        out_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_busB", busB, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
        chk("post_rst_busA", busA, 32'h0);
        chk("post_rst_busB", busB, 32'h0);

        // Random stimulus against the reference model
        do_reset();
        for (int r = 0; r < int'(NREG); r++) m_rf[r] = 32'h0;
        m_v = 1'b0; m_ctrl = '0; m_a = '0; m_b = '0; m_pc = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            rs_in = 5'($urandom_range(0, 7)); rt_in = 5'($urandom_range(0, 7));
            rd_in = 5'($urandom); imm16_in = 16'($urandom); pc_in = $urandom;
            ctrl_in = 24'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            wb_we = $urandom_range(0, 1) == 1;
            wb_jal = ($urandom_range(0, 7) == 0);
            wb_ovf = ($urandom_range(0, 7) == 0);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            tgt = wb_jal ? 5'd31 : wb_addr;
            live = wb_we && !wb_ovf && tgt != 5'd0;
            e_st = in_valid && ((m_v && m_ctrl[0] && m_rt != 5'd0 && (m_rt == rs_in || m_rt == rt_in))
                   || (!BYP && live && (tgt == rs_in || tgt == rt_in)));
            e_rdy = flush || ((!m_v || out_ready) && !e_st);
            @(negedge clk);
            chk("rnd_stall", {31'b0, stall}, {31'b0, e_st});
            chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
            if (flush || ((!m_v || out_ready) && e_st)) begin
                m_v = 1'b0; m_ctrl = '0;
            end else if (!m_v || out_ready) begin
                m_v = in_valid; m_ctrl = in_valid ? ctrl_in : 24'h0;
                m_a = m_read(rs_in, live, tgt); m_b = m_read(rt_in, live, tgt);
                m_pc = pc_in; m_imm = imm16_in; m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
            end
            if (live) m_rf[tgt] = wb_data;
            @(posedge clk);
            #1;
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_v});
            chk("rnd_ctrl", {8'b0, ctrl_out}, {8'b0, m_ctrl});
            if (m_v) begin
                chk("rnd_busA", busA, m_a);
                chk("rnd_busB", busB, m_b);
                chk("rnd_pc", pc_out, m_pc);
                chk("rnd_imm_regs", {1'b0, imm16_out, rs_out, rt_out, rd_out},
                    {1'b0, m_imm, m_rs, m_rt, m_rd});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter CTRL_W, default 24, width of the pre-decoded control bundle.
REQ-004 Parameter MEMRD_BIT, default 0, index of the load (MemToReg) bit inside the control bundle.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_valid  in  1  IF/ID holds a valid instruction.
REQ-008 in_ready  out  1  stage accepts the instruction this cycle.
REQ-009 rs_in, rt_in, rd_in  in  AW each  register fields.
REQ-010 imm16_in  in  16  immediate; pc_in  in  XLEN  instruction PC; ctrl_in  in  CTRL_W  decoded controls.
REQ-011 wb_we, wb_jal, wb_ovf  in  1 each  writeback enable, link write, overflow suppress.
REQ-012 wb_addr  in  AW; wb_data  in  XLEN  writeback port.
REQ-013 flush  in  1  squash the contents of ID/EX and the incoming instruction.
REQ-014 out_valid  out  1; out_ready  in  1  ID/EX handshake toward EX.
REQ-015 busA, busB  out  XLEN; pc_out  out  XLEN; imm16_out  out  16; rs_out, rt_out, rd_out  out  AW; ctrl_out  out  CTRL_W  registered ID/EX payload.
REQ-016 stall  out  1  load-use hazard detected this cycle.

Function
REQ-017 Register file SHALL hold NREG x XLEN entries; register 0 reads 0 and ignores writes.
REQ-018 Write SHALL occur at the clock edge when wb_we=1 and wb_ovf=0; target is NREG-1 when wb_jal=1, else wb_addr.
REQ-019 Reads SHALL be combinational on rs_in/rt_in and captured into busA/busB on acceptance (1-cycle latency ID to ID/EX).
REQ-020 stall SHALL be 1 when out_valid=1, ctrl_out[MEMRD_BIT]=1, rt_out!=0, in_valid=1, and rt_out equals rs_in or rt_in.
REQ-021 in_ready SHALL equal flush | ((~out_valid | out_ready) & ~stall).
REQ-022 On the edge with out_ready=1 or out_valid=0 and no flush: a stalled cycle SHALL load a bubble (out_valid=0); otherwise out_valid takes in_valid and the payload registers take the inputs.
REQ-023 When out_valid=1 and out_ready=0, all ID/EX registers SHALL hold unchanged, and stall/in_ready SHALL NOT admit a new instruction.
REQ-024 flush SHALL take priority over stall and handshake: next edge out_valid=0, incoming instruction consumed and discarded; register-file writes still occur.
REQ-025 Bubble and flushed entries SHALL clear ctrl_out to 0 so no downstream write or memory action results.

Reset
REQ-026 While rst=1: out_valid=0, all payload outputs 0, every register-file entry 0; effect immediate, independent of clk.
REQ-027 Reset asserted mid-stall or mid-backpressure SHALL discard held state; first accepted instruction after release sees all-zero registers.

Configuration
REQ-028 Macro ID_STAGE_BYPASS_EN defined: a read whose address equals the active write target (non-zero, write enabled, no overflow) SHALL return wb_data in the same cycle.
REQ-029 Macro undefined: no bypass; stall SHALL additionally assert when an active write targets a non-zero rs_in or rt_in of a valid instruction, delaying acceptance one cycle so the stored value is read.

Verification
REQ-030 Reset then write r5=0x1234 (wb_we=1), next cycle rs_in=5 with in_valid=1, out_ready=1 -> busA=0x1234, out_valid=1 one edge later.
REQ-031 Same-cycle write r7=0xA5A5 and read rt_in=7 -> with ID_STAGE_BYPASS_EN busB=0xA5A5 after one edge; without it stall=1 one cycle, then busB=0xA5A5.
REQ-032 Load (ctrl MEMRD_BIT=1, rt_out=3) in ID/EX, next instruction rs_in=3 -> stall=1, in_ready=0, one bubble (out_valid=0, ctrl_out=0), instruction issues next cycle.
REQ-033 wb_jal=1, wb_data=0x00400008 -> register 31 = 0x00400008; wb_ovf=1 with wb_addr=9 -> r9 unchanged; write to r0 -> r0 reads 0.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> payload stable, in_ready=0; flush=1 during stall -> out_valid=0 next edge, in_ready=1.
